// File: rtl/dram_pkg.sv
// Shared types and constants for the DRAM command sequencer: FSM states,
// default geometry, derived field widths and request address helpers.
package dram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    ACT  = 2'd2,
    RD   = 2'd3
  } state_e;

  localparam int DEF_NUM_OF_BANKS = 8;
  localparam int DEF_NUM_OF_ROWS  = 128;
  localparam int DEF_NUM_OF_COLS  = 8;

  localparam int BW = $clog2(DEF_NUM_OF_BANKS);
  localparam int RW = $clog2(DEF_NUM_OF_ROWS);
  localparam int CW = $clog2(DEF_NUM_OF_COLS);
  localparam int AW = BW + RW + CW;

  // Row-to-buffer path and read data path are each two registers deep.
  localparam int ACT_CYCLES_MIN = 2;
  localparam int RD_CYCLES_MIN  = 2;

  function automatic logic [BW-1:0] addr_bank(input logic [AW-1:0] addr);
    return addr[AW-1 -: BW];
  endfunction

  function automatic logic [RW-1:0] addr_row(input logic [AW-1:0] addr);
    return addr[CW +: RW];
  endfunction

  function automatic logic [CW-1:0] addr_col(input logic [AW-1:0] addr);
    return addr[CW-1:0];
  endfunction

  function automatic logic [AW-1:0] make_addr(input logic [BW-1:0] bank,
                                               input logic [RW-1:0] row,
                                               input logic [CW-1:0] col);
    return {bank, row, col};
  endfunction

endpackage

// File: rtl/dram_cmd_sequencer_if.sv
// Host-side request/response handshake of the DRAM command sequencer.
interface dram_cmd_sequencer_if #(
  parameter int ADDR_W = dram_pkg::AW
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic              req_wdata;
  logic              rsp_valid;
  logic              rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/dram_open_row_table.sv
// Per-bank open-row tags: lookup (bank,row)->hit, set on activate exit,
// invalidate on a write to the currently buffered row.
module dram_open_row_table #(
  parameter int NUM_OF_BANKS = 8,
  parameter int ROW_W        = 7,
  localparam int BANK_W      = $clog2(NUM_OF_BANKS)
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [BANK_W-1:0] lk_bank,
  input  logic [ROW_W-1:0]  lk_row,
  output logic              lk_hit,
  input  logic              set_en,
  input  logic [BANK_W-1:0] set_bank,
  input  logic [ROW_W-1:0]  set_row,
  input  logic              inv_en,
  input  logic [BANK_W-1:0] inv_bank,
  input  logic [ROW_W-1:0]  inv_row
);
  logic [NUM_OF_BANKS-1:0] valid_q, valid_d;
  logic [ROW_W-1:0]        row_q [NUM_OF_BANKS];
  logic [ROW_W-1:0]        row_d [NUM_OF_BANKS];

  assign lk_hit = valid_q[lk_bank] && (row_q[lk_bank] == lk_row);

  always_comb begin
    valid_d = valid_q;
    row_d   = row_q;
    for (int i = 0; i < NUM_OF_BANKS; i++) begin
      if (set_en && set_bank == BANK_W'(i)) begin
        valid_d[i] = 1'b1;
        row_d[i]   = set_row;
      end else if (inv_en && inv_bank == BANK_W'(i) && row_q[i] == inv_row) begin
        valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_OF_BANKS; i++) row_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      row_q   <= row_d;
    end
  end
endmodule

// File: rtl/dram_cmd_sequencer.sv
// Converts single-bit host read/write requests into DRAM command cycles and
// owns the shared data line. DRAM_SEQ_OPEN_ROW_EN enables open-row read hits.
module dram_cmd_sequencer
  import dram_pkg::*;
#(
  parameter int NUM_OF_BANKS = DEF_NUM_OF_BANKS,
  parameter int NUM_OF_ROWS  = DEF_NUM_OF_ROWS,
  parameter int NUM_OF_COLS  = DEF_NUM_OF_COLS,
  parameter int ACT_CYCLES   = 2,
  parameter int RD_CYCLES    = 2,
  localparam int BANK_W      = $clog2(NUM_OF_BANKS),
  localparam int ROW_W       = $clog2(NUM_OF_ROWS),
  localparam int COL_W       = $clog2(NUM_OF_COLS)
) (
  input  logic                 clk,
  input  logic                 rst_b,
  dram_cmd_sequencer_if.slave  host,
  output logic                 bank_rw,
  output logic                 buffer_rw,
  output logic [BANK_W-1:0]    bank_id,
  output logic [ROW_W-1:0]     rowid,
  output logic [COL_W-1:0]     colid,
  inout  wire                  data
);
  localparam int ADDR_W = BANK_W + ROW_W + COL_W;
  localparam int ACT_N  = (ACT_CYCLES < ACT_CYCLES_MIN) ? ACT_CYCLES_MIN : ACT_CYCLES;
  localparam int RD_N   = (RD_CYCLES < RD_CYCLES_MIN) ? RD_CYCLES_MIN : RD_CYCLES;
  localparam int MAX_N  = (ACT_N > RD_N) ? ACT_N : RD_N;
  localparam int CNT_W  = $clog2(MAX_N) + 1;
  localparam logic [CNT_W-1:0] ACT_LOAD = CNT_W'(ACT_N - 1);
  localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_N - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BANK_W-1:0] bank_id_q, bank_id_d;
  logic [ROW_W-1:0]  rowid_q, rowid_d;
  logic [COL_W-1:0]  colid_q, colid_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_rdata_q, rsp_rdata_d;

  logic [BANK_W-1:0] req_bank;
  logic [ROW_W-1:0]  req_row;
  logic [COL_W-1:0]  req_col;
  logic              accept;
  logic              rd_hit;

  assign req_bank = host.req_addr[ADDR_W-1 -: BANK_W];
  assign req_row  = host.req_addr[COL_W +: ROW_W];
  assign req_col  = host.req_addr[COL_W-1:0];
  assign accept   = host.req_valid && (state_q == IDLE);

`ifdef DRAM_SEQ_OPEN_ROW_EN
  dram_open_row_table #(
    .NUM_OF_BANKS (NUM_OF_BANKS),
    .ROW_W        (ROW_W)
  ) u_open_row_table (
    .clk      (clk),
    .rst_b    (rst_b),
    .lk_bank  (req_bank),
    .lk_row   (req_row),
    .lk_hit   (rd_hit),
    .set_en   (state_q == ACT && cnt_q == '0),
    .set_bank (bank_id_q),
    .set_row  (rowid_q),
    .inv_en   (state_q == WR),
    .inv_bank (bank_id_q),
    .inv_row  (rowid_q)
  );
`else
  assign rd_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bank_id_q   <= '0;
      rowid_q     <= '0;
      colid_q     <= '0;
      col_q       <= '0;
      wdata_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bank_id_q   <= bank_id_d;
      rowid_q     <= rowid_d;
      colid_q     <= colid_d;
      col_q       <= col_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Address outputs only change on entry to the command that consumes them.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bank_id_d   = bank_id_q;
    rowid_d     = rowid_q;
    colid_d     = colid_q;
    col_d       = col_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          bank_id_d = req_bank;
          col_d     = req_col;
          wdata_d   = host.req_wdata;
          if (host.req_write) begin
            state_d = WR;
            rowid_d = req_row;
            colid_d = req_col;
            cnt_d   = '0;
          end else if (rd_hit) begin
            state_d = RD;
            colid_d = req_col;
            cnt_d   = RD_LOAD;
          end else begin
            state_d = ACT;
            rowid_d = req_row;
            cnt_d   = ACT_LOAD;
          end
        end
      end
      WR: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = 1'b0;
      end
      ACT: begin
        if (cnt_q == '0) begin
          state_d = RD;
          colid_d = col_q;
          cnt_d   = RD_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RD: begin
        if (cnt_q == '0) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = data;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bank_rw        = 1'b0;
    buffer_rw      = 1'b0;
    host.req_ready = (state_q == IDLE);
    host.rsp_valid = rsp_valid_q;
    host.rsp_rdata = rsp_rdata_q;
    unique case (state_q)
      WR:      bank_rw   = 1'b1;
      ACT:     buffer_rw = 1'b1;
      default: ;
    endcase
  end

  assign bank_id = bank_id_q;
  assign rowid   = rowid_q;
  assign colid   = colid_q;

  // The line is released whenever the memory could be driving it.
  assign data = bank_rw ? wdata_q : 1'bz;
endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// Directed bench for dram_cmd_sequencer with a small banked DRAM model on the
// shared data line; a pullup makes a released line read as 1.
module tb_dram_cmd_sequencer;
  import dram_pkg::*;

`ifdef DRAM_SEQ_OPEN_ROW_EN
  localparam int HIT_LAT = 3;
  localparam int HIT_ACT = 0;
`else
  localparam int HIT_LAT = 5;
  localparam int HIT_ACT = 2;
`endif

  logic          clk;
  logic          rst_b;
  logic          bank_rw;
  logic          buffer_rw;
  logic [BW-1:0] bank_id;
  logic [RW-1:0] rowid;
  logic [CW-1:0] colid;
  wire           data;

  int vectors = 0;
  int miscompares = 0;

  dram_cmd_sequencer_if host ();

  dram_cmd_sequencer dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .host      (host),
    .bank_rw   (bank_rw),
    .buffer_rw (buffer_rw),
    .bank_id   (bank_id),
    .rowid     (rowid),
    .colid     (colid),
    .data      (data)
  );

  pullup (data);

  // Memory model: array write on bank_rw, row copy into bank buffer on
  // buffer_rw, registered buffer read driven whenever no command strobe is up.
  logic [7:0] mem [8][128] = '{default: '0};
  logic [7:0] buf_q [8];
  logic       mem_rd_q;
  logic       mem_oe;

  assign mem_oe = rst_b && !bank_rw && !buffer_rw;
  assign data   = mem_oe ? mem_rd_q : 1'bz;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int b = 0; b < 8; b++) buf_q[b] <= '0;
      mem_rd_q <= 1'b0;
    end else begin
      if (bank_rw) mem[bank_id][rowid][colid] <= data;
      if (buffer_rw) buf_q[bank_id] <= mem[bank_id][rowid];
      mem_rd_q <= buf_q[bank_id][colid];
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  // Issues one request and follows it to its response, checking latency,
  // activate length, command fields, line ownership and read data.
  task automatic do_req(input string tag, input logic wr, input int b, input int r,
                        input int c, input logic wd, input int exp_lat,
                        input int exp_act, input logic exp_rd);
    int   guard;
    int   lat;
    int   act_cnt;
    int   bad;
    logic seen;
    guard = 0;
    while (host.req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_ready"}, 32'(host.req_ready), 32'd1);
    host.req_valid = 1'b1;
    host.req_write = wr;
    host.req_addr  = make_addr(BW'(b), RW'(r), CW'(c));
    host.req_wdata = wd;
    @(negedge clk);
    host.req_valid = 1'b0;
    host.req_wdata = 1'b0;
    lat = 1;
    act_cnt = 0;
    bad = 0;
    seen = 1'b0;
    while (!seen && lat <= 12) begin
      if (host.rsp_valid === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (buffer_rw === 1'b1) begin
          act_cnt++;
          if (data !== 1'b1 || bank_rw !== 1'b0 || bank_id !== BW'(b) || rowid !== RW'(r)) bad++;
        end else if (bank_rw === 1'b1) begin
          if (data !== wd || bank_id !== BW'(b) || rowid !== RW'(r) || colid !== CW'(c)) bad++;
        end else begin
          if (bank_id !== BW'(b) || colid !== CW'(c)) bad++;
        end
        @(negedge clk);
        lat++;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_act_cycles"}, 32'(act_cnt), 32'(exp_act));
    chk({tag, "_cmd_errors"}, 32'(bad), 32'd0);
    chk({tag, "_rdata"}, 32'(host.rsp_rdata), 32'(exp_rd));
    $display("req %s wr=%0d bank=%0d row=%0d col=%0d lat=%0d act=%0d rdata=%0d",
             tag, wr, b, r, c, lat, act_cnt, host.rsp_rdata);
  endtask

  initial begin
    int rsp_seen;
    rst_b          = 1'b0;
    host.req_valid = 1'b0;
    host.req_write = 1'b0;
    host.req_addr  = '0;
    host.req_wdata = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(host.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(host.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(host.rsp_rdata), 32'd0);
    chk("rst_bank_rw", 32'(bank_rw), 32'd0);
    chk("rst_buffer_rw", 32'(buffer_rw), 32'd0);
    chk("rst_bank_id", 32'(bank_id), 32'd0);
    chk("rst_rowid", 32'(rowid), 32'd0);
    chk("rst_colid", 32'(colid), 32'd0);
    chk("rst_data_released", 32'(data), 32'd1);
    rst_b = 1'b1;
    @(negedge clk);

    do_req("w_b3r5c2", 1'b1, 3, 5, 2, 1'b1, 2, 0, 1'b0);
    do_req("r_b3r5c2", 1'b0, 3, 5, 2, 1'b0, 5, 2, 1'b1);
    do_req("r_b3r5c7", 1'b0, 3, 5, 7, 1'b0, HIT_LAT, HIT_ACT, 1'b0);
    do_req("w_b3r5c7", 1'b1, 3, 5, 7, 1'b1, 2, 0, 1'b0);
    do_req("r_b3r5c7_inv", 1'b0, 3, 5, 7, 1'b0, 5, 2, 1'b1);
    do_req("w_b0r1c0", 1'b1, 0, 1, 0, 1'b1, 2, 0, 1'b0);
    do_req("w_b1r3c4", 1'b1, 1, 3, 4, 1'b1, 2, 0, 1'b0);
    do_req("w_b4r0c3_zero", 1'b1, 4, 0, 3, 1'b0, 2, 0, 1'b0);
    do_req("r_b4r0c3", 1'b0, 4, 0, 3, 1'b0, 5, 2, 1'b0);
    do_req("r_b0r1c0_open", 1'b0, 0, 1, 0, 1'b0, 5, 2, 1'b1);
    do_req("r_b1r2c0_open", 1'b0, 1, 2, 0, 1'b0, 5, 2, 1'b0);
    do_req("r_b0r1c0_hit", 1'b0, 0, 1, 0, 1'b0, HIT_LAT, HIT_ACT, 1'b1);
    do_req("r_b1r3c4_miss", 1'b0, 1, 3, 4, 1'b0, 5, 2, 1'b1);
    do_req("r_b1r3c4_hit", 1'b0, 1, 3, 4, 1'b0, HIT_LAT, HIT_ACT, 1'b1);
    do_req("w_b2r9c1", 1'b1, 2, 9, 1, 1'b1, 2, 0, 1'b0);

    // Reset asserted during the second activate cycle of a read miss.
    host.req_valid = 1'b1;
    host.req_write = 1'b0;
    host.req_addr  = make_addr(BW'(2), RW'(9), CW'(1));
    @(negedge clk);
    host.req_valid = 1'b0;
    chk("abort_act1", 32'(buffer_rw), 32'd1);
    @(negedge clk);
    chk("abort_act2", 32'(buffer_rw), 32'd1);
    rst_b = 1'b0;
    #1;
    chk("abort_buffer_rw", 32'(buffer_rw), 32'd0);
    chk("abort_bank_rw", 32'(bank_rw), 32'd0);
    chk("abort_rsp_valid", 32'(host.rsp_valid), 32'd0);
    chk("abort_data_released", 32'(data), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    rsp_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (host.rsp_valid === 1'b1) rsp_seen++;
    end
    chk("abort_no_rsp", 32'(rsp_seen), 32'd0);
    chk("abort_ready", 32'(host.req_ready), 32'd1);
    $display("req abort_b2r9c1 reset during ACT, responses seen=%0d", rsp_seen);
    do_req("r_b2r9c1_after_rst", 1'b0, 2, 9, 1, 1'b0, 5, 2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dram_cmd_sequencer.md
Name: dram_cmd_sequencer

Overview:
Host-side command sequencer that sits directly upstream of the banked DRAM model. It converts single-bit host read/write requests, carried on a valid/ready interface, into bank_rw / buffer_rw / bank_id / rowid / colid command cycles. It owns the shared tristate data line: it drives the line on writes and samples it on reads. It tracks the open row per bank so that reads to an already-buffered row skip activation.

Parameters:
NUM_OF_BANKS, 8, bank count; bank field is $clog2 wide
NUM_OF_ROWS, 128, rows per bank
NUM_OF_COLS, 8, columns per row
ACT_CYCLES, 2, cycles buffer_rw is held per activate (minimum 2: row-to-buffer path is 2 registers deep)
RD_CYCLES, 2, cycles of read command before sampling data (minimum 2: read data is registered)

Ports:
clk  in  1  clock
rst_b  in  1  asynchronous active-low reset
req_valid  in  1  host request valid
req_ready  out  1  sequencer can accept a request
req_write  in  1  1 = write, 0 = read
req_addr  in  BW+RW+CW  {bank, row, col}; bank field is MSBs
req_wdata  in  1  write data bit
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  1  read data (0 for writes)
bank_rw  out  1  memory write strobe
buffer_rw  out  1  row-activate strobe
bank_id  out  BW  target bank
rowid  out  RW  target row
colid  out  CW  target column
data  inout  1  shared data line

Behaviour:
- Reset is asynchronous. On reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, bank_rw=0, buffer_rw=0, bank_id/rowid/colid=0, data=Z, all open-row tags invalid, cycle counter=0.
- Reset mid-operation aborts the request with no response. Tags are invalidated, which is consistent with the memory clearing its buffers on reset.
- FSM states:
  - IDLE: req_ready=1; the request is latched on req_valid&&req_ready.
  - From IDLE: write -> WR; read hit -> RD; read miss -> ACT.
  - WR: 1 cycle. bank_rw=1, buffer_rw=0, data driven with latched wdata. -> DONE.
  - ACT: buffer_rw=1, bank_rw=0, rowid=latched row, for ACT_CYCLES cycles. On exit, tag[bank] <= {valid, row}. -> RD.
  - RD: bank_rw=0, buffer_rw=0, colid=latched col, for RD_CYCLES cycles. data is sampled at the rising edge ending the last RD cycle. -> DONE.
  - DONE: exists only as a registered transition. rsp_valid=1 in the first IDLE cycle after the last command cycle; req_ready is also 1 in that cycle, so back-to-back requests are accepted.
- Latency from the acceptance edge to the rsp_valid cycle:
  - write: 2 cycles
  - read hit: RD_CYCLES+1 (=3)
  - read miss: ACT_CYCLES+RD_CYCLES+1 (=5)
- Hit condition: tag[bank].valid && tag[bank].row==row.
- Writes go straight to the array and do not update the bank buffer. A write whose row equals tag[bank].row clears tag[bank].valid at the WR edge.
- Tristate rule: data is driven only while bank_rw=1. Otherwise it is Z. The controller never drives while the memory drives (bank_rw=0 && buffer_rw=0).
- In IDLE and during ACT, bank_id/rowid/colid hold their last values. They are not required to return to 0 after reset.
- rsp_rdata holds its value until the next response.
- Simultaneous events: only one request is outstanding at a time. req_valid outside IDLE is ignored and never dropped; the host holds it until ready.
- Counter width is $clog2(max(ACT_CYCLES,RD_CYCLES))+1. The counter reloads on each state entry.

Optional Feature:
DRAM_SEQ_OPEN_ROW_EN
- Defined: open-page policy with per-bank tags, as above.
- Undefined: no tag table. Every read goes through ACT (read latency is always 5), and the write invalidation logic is absent.

Decomposition:
- Package dram_pkg holds:
  - the state enum (IDLE, WR, ACT, RD)
  - default bank/row/col counts and derived widths BW/RW/CW
  - address field slice helpers
  - ACT/RD minimum constants
- Natural sub-module: dram_open_row_table. It holds per-bank valid+row registers, a lookup port (bank, row -> hit), a set port (ACT exit) and an invalidate port (WR row match). It is instantiated only under DRAM_SEQ_OPEN_ROW_EN.

Test Plan:
- Reset, then write bank3 row5 col2 = 1, then read the same address -> write rsp 2 cycles after acceptance; read shows buffer_rw high 2 cycles then rsp_valid 5 cycles after acceptance with rsp_rdata=1.
- Read bank3 row5 col7 immediately after -> hit: no buffer_rw, rsp_valid after 3 cycles, rsp_rdata=0.
- Write bank3 row5 col7 = 1, then read it -> tag invalidated, ACT reissued, rsp_rdata=1 after 5 cycles.
- Open bank0 row1 and bank1 row2, then read bank0 row1 col0 -> hit (3 cycles); read bank1 row3 -> miss (5 cycles).
- Assert rst_b low during the 2nd ACT cycle -> all strobes 0 immediately, req_ready=1 after release, no rsp_valid, next read of same row misses.
- Throughout: data is Z whenever bank_rw=0. Without DRAM_SEQ_OPEN_ROW_EN, every read takes 5 cycles.
